// File: rtl/fir_param.sv
// fir_param: parametrised direct-form FIR filter, W-bit Q1.(W-1) samples/coefs, N taps.
// Latency: PIPE cycles from VIN to VOUT; one sample per cycle sustained.
// Backpressure: none; the sink must take every VOUT pulse.
// Ports: CLK/RST_n (async active-low); DIN/VIN input sample + valid;
//        B flat coefficient bus (tap k at B[k*W +: W]); DOUT/VOUT result + valid pulse.
module fir_param #(
  parameter int W    = 14,
  parameter int N    = 11,
  parameter int SAT  = 1,
  parameter int PIPE = 1
) (
  input  logic                CLK,
  input  logic                RST_n,
  input  logic signed [W-1:0] DIN,
  input  logic                VIN,
  input  logic [N*W-1:0]      B,
  output logic signed [W-1:0] DOUT,
  output logic                VOUT
);

  localparam int PW = 2 * W;
  localparam int AW = 2 * W + $clog2(N);

  // Output range of a W-bit signed sample, at accumulator width.
  localparam logic signed [AW-1:0] QMAX = AW'((64'sd1 <<< (W - 1)) - 64'sd1);
  localparam logic signed [AW-1:0] QMIN = ~QMAX;

  // Delay line: x_q[k] holds the sample accepted k samples ago.
  logic signed [W-1:0]  x_q  [1:N-1];
  logic signed [W-1:0]  tap  [0:N-1];
  logic signed [W-1:0]  coef [0:N-1];
  logic signed [PW-1:0] prod [0:N-1];

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      for (int k = 1; k < N; k++) x_q[k] <= '0;
    end else if (VIN) begin
      x_q[1] <= DIN;
      for (int k = 2; k < N; k++) x_q[k] <= x_q[k-1];
    end
  end

  // Tap 0 is the incoming sample itself; the product uses pre-shift history.
  for (genvar k = 0; k < N; k++) begin : g_tap
    if (k == 0) begin : g_t0
      assign tap[k] = DIN;
    end else begin : g_tk
      assign tap[k] = x_q[k];
    end
    assign coef[k] = B[k*W +: W];
    assign prod[k] = PW'(coef[k]) * PW'(tap[k]);
  end

  // Products feeding the adder tree, and the valid bit of that stage.
  logic signed [PW-1:0] sum_src [0:N-1];
  logic                 stage_vld;

  if (PIPE == 2) begin : g_pipe2
    logic signed [PW-1:0] prod_q [0:N-1];
    logic                 vld_q;

    always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
        for (int k = 0; k < N; k++) prod_q[k] <= '0;
        vld_q <= 1'b0;
      end else begin
        vld_q <= VIN;
        if (VIN) begin
          for (int k = 0; k < N; k++) prod_q[k] <= prod[k];
        end
      end
    end

    for (genvar k = 0; k < N; k++) begin : g_src
      assign sum_src[k] = prod_q[k];
    end
    assign stage_vld = vld_q;
  end else begin : g_pipe1
    for (genvar k = 0; k < N; k++) begin : g_src
      assign sum_src[k] = prod[k];
    end
    assign stage_vld = VIN;
  end

  // Sum with log2(N) guard bits, then arithmetic shift back to Q1.(W-1).
  logic signed [AW-1:0] acc;
  logic signed [AW-1:0] q;
  logic signed [W-1:0]  y;

  always_comb begin
    acc = '0;
    for (int k = 0; k < N; k++) begin
      acc = acc + {{(AW-PW){sum_src[k][PW-1]}}, sum_src[k]};
    end
    q = acc >>> (W - 1);
    y = q[W-1:0];
    if (SAT != 0) begin
      if (q > QMAX)      y = QMAX[W-1:0];
      else if (q < QMIN) y = QMIN[W-1:0];
    end
  end

  // Output stage: DOUT only moves on a valid result, otherwise holds.
  logic signed [W-1:0] dout_q;
  logic signed [W-1:0] dout_d;
  logic                vout_q;

  assign dout_d = stage_vld ? y : dout_q;

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      dout_q <= '0;
      vout_q <= 1'b0;
    end else begin
      dout_q <= dout_d;
      vout_q <= stage_vld;
    end
  end

  assign DOUT = dout_q;
  assign VOUT = vout_q;

endmodule

// File: doc/fir_param.md
# fir_param

Parametrised direct-form FIR filter and the next generation of the fixed 11-tap, 14-bit `FIR` block. Tap count, sample/coefficient width, output saturation and pipeline depth are all configurable. It uses the same VIN/VOUT valid-qualified streaming interface, so it drops into the existing clk_gen / data_maker / data_sink bench. Coefficients are supplied as one flat bus instead of per-tap ports.

## Interface
- `W`, 14: sample and coefficient width, signed two's complement, Q1.(W-1); range 4..24.
- `N`, 11: number of taps; range 2..32.
- `SAT`, 1: 1 = saturate output to W bits; 0 = wrap (keep low W bits).
- `PIPE`, 1: 1 = output register only; 2 = additional product register stage.
- `CLK` in 1: single clock; all state updates on the rising edge.
- `RST_n` in 1: asynchronous, active-low reset.
- `DIN` in W: input sample, signed.
- `VIN` in 1: DIN valid this cycle.
- `B` in N*W: coefficients; tap k is `B[k*W +: W]`, signed; must be static while samples are in flight.
- `DOUT` out W: filtered sample, signed.
- `VOUT` out 1: DOUT valid; one-cycle pulse per result.

## Operation
- Delay line: x[1..N-1], W bits each.
  - When VIN=1: x[1]<=DIN and x[k]<=x[k-1].
  - When VIN=0: delay line holds.
- Result for an accepted sample: y = B0*DIN + sum over k=1..N-1 of Bk*x[k], using pre-shift delay-line contents.
- Arithmetic widths:
  - Products are full precision, 2W bits signed.
  - Accumulator is 2W+ceil(log2 N) bits signed; no internal overflow is possible.
- Quantisation:
  - q = acc >>> (W-1), arithmetic shift (truncation toward -inf).
  - SAT=1: clamp q to [-2^(W-1), 2^(W-1)-1].
  - SAT=0: DOUT = q[W-1:0].
- PIPE=1: products and sum are combinational; quantised y is registered into DOUT in the cycle VIN=1.
- PIPE=2:
  - Stage 1 registers the N products plus a valid bit.
  - Stage 2 sums, quantises and registers into DOUT/VOUT.
- Valid pipeline: a PIPE-deep shift of VIN. VOUT is the last stage.
- DOUT updates only when its stage valid is 1, and otherwise holds its last value.
- No backpressure: the sink must accept every VOUT pulse.
- Reset (async assert, any time):
  - Delay line, product registers, DOUT = 0; all valid bits and VOUT = 0.
  - In-flight samples are discarded.
  - The first sample after release sees an all-zero history.

## Timing
- Latency: VIN=1 at edge t produces VOUT=1 and DOUT valid after edge t+PIPE-1, i.e. visible in cycle t+PIPE.
- Throughput: one sample per cycle. Back-to-back VIN gives back-to-back VOUT.
- Bubbles: the VOUT pattern equals the VIN pattern delayed by PIPE cycles. Results are identical to a gap-free stream of the same valid samples.
- Coefficient change: takes effect for samples whose multiply stage occurs after the change. Changing B while samples are in flight is undefined for those samples only.
- Reset release: the first VIN may arrive in the first cycle after RST_n rises.
- Critical path:
  - PIPE=1: N multipliers plus an adder tree.
  - PIPE=2: the adder tree plus the quantiser.

## Test plan
- **Impulse** (W=14, N=11, SAT=1, PIPE=1).
  - Stimulus: Bk = 200*(k+1); DIN = 4096 for one sample, then 0 for 12 samples.
  - Response: DOUT = 100, 200, … 1100, then 0; each VOUT 1 cycle after its VIN.
- **Saturation.**
  - Stimulus: all Bk = 8191; DIN = 8191 for 11 samples.
  - SAT=1: DOUT ramps and clamps at 8191.
  - SAT=0: DOUT equals the low 14 bits of acc>>>13.
  - Negative case: DIN = -8192, Bk = 8191; SAT=1 response clamps to -8192.
- **Truncation sign.**
  - Stimulus: B0 = 1, other taps 0; DIN = -1, then DIN = 1.
  - Response: DOUT = -1 (0x3FFF), then 0.
- **Bubbles.**
  - Stimulus: impulse test with VIN pattern 1,0,0,1,0,1,… instead of continuous.
  - Response: same DOUT value sequence; VOUT mirrors VIN delayed by PIPE; DOUT holds during gaps.
- **PIPE=2.**
  - Stimulus: impulse test repeated with continuous VIN.
  - Response: identical values, latency 2, one result per cycle with no gaps.
- **Reset mid-stream.**
  - Stimulus: assert RST_n low asynchronously (between edges) while 2 results are in flight.
  - Response: DOUT = 0 and VOUT = 0 immediately; no stale VOUT after release.
  - Post-reset: a new impulse reproduces the first test's sequence exactly.
